// File: rtl/servo_pwm_multi.sv
// N-channel servo PWM driver: each channel ramps its position toward a commanded
// target and emits a servo pulse whose width only changes at period boundaries.
module servo_pwm_multi #(
  parameter int CLK_FREQ_HZ   = 50_000_000,
  parameter int PERIOD_MS     = 20,
  parameter int MIN_PULSE_US  = 600,
  parameter int MAX_PULSE_US  = 2400,
  parameter int N_CH          = 2,
  parameter int POS_W         = 8,
  parameter int STEP_DELAY_US = 8000,
  parameter int RESET_POS     = 2**(POS_W-1)-1,
  localparam int CH_W         = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [CH_W-1:0]  cmd_ch_i,
  input  logic [POS_W-1:0] cmd_pos_i,
  input  logic             cmd_snap_i,
  input  logic             hold_i,
  output logic [N_CH-1:0]  pwm_out_o,
  output logic [N_CH-1:0]  at_target_o,
  output logic             cmd_err_o
);

  localparam int CYC_PER_US = CLK_FREQ_HZ / 1_000_000;
  localparam int PERIOD_CYC = CLK_FREQ_HZ / 1000 * PERIOD_MS;
  localparam int MIN_CYC    = MIN_PULSE_US * CYC_PER_US;
  localparam int MAX_CYC    = MAX_PULSE_US * CYC_PER_US;
  localparam int STEP_CYC   = STEP_DELAY_US * CYC_PER_US;
  localparam int SPAN_CYC   = MAX_CYC - MIN_CYC;
  localparam int POS_MAX    = 2**POS_W - 1;
  localparam int WID_W      = $clog2(((PERIOD_CYC > MAX_CYC) ? PERIOD_CYC : MAX_CYC) + 1);
  localparam int STEP_W     = $clog2(STEP_CYC + 1);

  localparam logic [POS_W-1:0] RESET_P   = POS_W'(RESET_POS);
  localparam logic [WID_W-1:0] RESET_WID =
    WID_W'(longint'(MIN_CYC) + (longint'(SPAN_CYC) * longint'(RESET_POS)) / longint'(POS_MAX));

  // 40-bit intermediate holds SPAN_CYC * POS_MAX for every legal parameter set
  function automatic logic [WID_W-1:0] pos_to_width(input logic [POS_W-1:0] p);
    logic [39:0] prod;
    prod = 40'(SPAN_CYC) * 40'(p);
    return WID_W'(40'(MIN_CYC) + prod / 40'(POS_MAX));
  endfunction

  logic [WID_W-1:0]  cnt_q, cnt_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [POS_W-1:0]  cur_q  [N_CH];
  logic [POS_W-1:0]  cur_d  [N_CH];
  logic [POS_W-1:0]  tgt_q  [N_CH];
  logic [POS_W-1:0]  tgt_d  [N_CH];
  logic [WID_W-1:0]  pend_q [N_CH];
  logic [WID_W-1:0]  pend_d [N_CH];
  logic [WID_W-1:0]  act_q  [N_CH];
  logic [WID_W-1:0]  act_d  [N_CH];
  logic [N_CH-1:0]   pwm_q, pwm_d;
  logic [N_CH-1:0]   at_q, at_d;
  logic              err_q, err_d;
  logic              period_end, step_tick, cmd_acc, hit;

  assign cmd_ready_o = ~reset_i;
  assign pwm_out_o   = pwm_q;
  assign at_target_o = at_q;
  assign cmd_err_o   = err_q;

  always_comb begin
    period_end = (cnt_q == WID_W'(PERIOD_CYC - 1));
    cnt_d      = period_end ? '0 : cnt_q + 1'b1;
    step_tick  = ~hold_i && (step_q == STEP_W'(STEP_CYC - 1));
    if (hold_i)
      step_d = step_q;
    else if (step_tick)
      step_d = '0;
    else
      step_d = step_q + 1'b1;
    cmd_acc = cmd_valid_i & cmd_ready_o;
    err_d   = cmd_acc && (int'(cmd_ch_i) >= N_CH);
    hit     = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      hit      = cmd_acc && (int'(cmd_ch_i) == i);
      tgt_d[i] = hit ? cmd_pos_i : tgt_q[i];
      // A command on this channel wins; the ramp step compares against the old target
      if (hit && cmd_snap_i)
        cur_d[i] = cmd_pos_i;
      else if (step_tick && (cur_q[i] < tgt_q[i]))
        cur_d[i] = cur_q[i] + 1'b1;
      else if (step_tick && (cur_q[i] > tgt_q[i]))
        cur_d[i] = cur_q[i] - 1'b1;
      else
        cur_d[i] = cur_q[i];
      at_d[i]   = (cur_d[i] == tgt_d[i]);
      pend_d[i] = pos_to_width(cur_q[i]);
      act_d[i]  = period_end ? pend_q[i] : act_q[i];
      pwm_d[i]  = (cnt_q < act_q[i]);
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_q  <= '0;
      step_q <= '0;
      pwm_q  <= '0;
      at_q   <= '1;
      err_q  <= 1'b0;
      for (int i = 0; i < N_CH; i++) begin
        cur_q[i]  <= RESET_P;
        tgt_q[i]  <= RESET_P;
        pend_q[i] <= RESET_WID;
        act_q[i]  <= RESET_WID;
      end
    end else begin
      cnt_q  <= cnt_d;
      step_q <= step_d;
      pwm_q  <= pwm_d;
      at_q   <= at_d;
      err_q  <= err_d;
      for (int i = 0; i < N_CH; i++) begin
        cur_q[i]  <= cur_d[i];
        tgt_q[i]  <= tgt_d[i];
        pend_q[i] <= pend_d[i];
        act_q[i]  <= act_d[i];
      end
    end
  end

endmodule

// File: tb/tb_servo_pwm_multi.sv
// Scoreboard bench for servo_pwm_multi: stimulus queues expected pulse widths,
// at_target transitions and cmd_err pulses; a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_servo_pwm_multi;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       cmd_valid, cmd_snap, hold, cmd_ch, cmd_ready, cmd_err;
  logic [7:0] cmd_pos;
  logic [1:0] pwm, at_tgt;

  logic       c3_valid, c3_snap, c3_ready, err3;
  logic [1:0] c3_ch;
  logic [7:0] c3_pos;
  logic [2:0] pwm3, at3;

  servo_pwm_multi #(
    .CLK_FREQ_HZ(1_000_000), .PERIOD_MS(1), .MIN_PULSE_US(100), .MAX_PULSE_US(900),
    .N_CH(2), .POS_W(8), .STEP_DELAY_US(10)
  ) dut (
    .clk_i(clk), .reset_i(rst), .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_ch_i(cmd_ch), .cmd_pos_i(cmd_pos), .cmd_snap_i(cmd_snap), .hold_i(hold),
    .pwm_out_o(pwm), .at_target_o(at_tgt), .cmd_err_o(cmd_err)
  );

  // Three-channel instance so an out-of-range channel index is encodable
  servo_pwm_multi #(
    .CLK_FREQ_HZ(1_000_000), .PERIOD_MS(1), .MIN_PULSE_US(100), .MAX_PULSE_US(900),
    .N_CH(3), .POS_W(8), .STEP_DELAY_US(10)
  ) dut3 (
    .clk_i(clk), .reset_i(rst), .cmd_valid_i(c3_valid), .cmd_ready_o(c3_ready),
    .cmd_ch_i(c3_ch), .cmd_pos_i(c3_pos), .cmd_snap_i(c3_snap), .hold_i(1'b0),
    .pwm_out_o(pwm3), .at_target_o(at3), .cmd_err_o(err3)
  );

  typedef struct {
    int   ch;
    logic val;
    int   cyc;
  } at_exp_t;

  at_exp_t at_exp_q[$];
  int      w0_q[$];
  int      w1_q[$];
  int      err3_q[$];
  int      checks = 0;
  int      errors = 0;
  int      cyc;
  int      hi[2];
  logic [1:0] pwm_prev;
  logic [1:0] at_prev;

  always @(posedge clk or posedge rst)
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;

  task automatic check_val(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  task automatic check_pulse(input int c, input int w);
    int e;
    checks++;
    if ((c == 0 && w0_q.size() == 0) || (c == 1 && w1_q.size() == 0)) begin
      errors++;
      $display("FAIL pulse_ch%0d: got %0d high cycles at cycle %0d, want no pulse", c, w, cyc);
    end else begin
      if (c == 0) e = w0_q.pop_front();
      else        e = w1_q.pop_front();
      if (w != e) begin
        errors++;
        $display("FAIL pulse_ch%0d: got %0d high cycles, want %0d (cycle %0d)", c, w, e, cyc);
      end
    end
  endtask

  task automatic check_at(input int c, input logic v);
    at_exp_t e;
    checks++;
    if (at_exp_q.size() == 0) begin
      errors++;
      $display("FAIL at_target_ch%0d: changed to %0b at cycle %0d, want no change", c, v, cyc);
    end else begin
      e = at_exp_q.pop_front();
      if (e.ch != c || e.val != v || e.cyc != cyc) begin
        errors++;
        $display("FAIL at_target: got ch%0d=%0b at cycle %0d, want ch%0d=%0b at cycle %0d",
                 c, v, cyc, e.ch, e.val, e.cyc);
      end
    end
  endtask

  task automatic check_err3();
    int e;
    checks++;
    if (err3_q.size() == 0) begin
      errors++;
      $display("FAIL cmd_err3: high at cycle %0d, want low", cyc);
    end else begin
      e = err3_q.pop_front();
      if (e != cyc) begin
        errors++;
        $display("FAIL cmd_err3: pulse at cycle %0d, want cycle %0d", cyc, e);
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      hi[0]    = 0;
      hi[1]    = 0;
      pwm_prev = 2'b00;
      at_prev  = 2'b11;
    end else begin
      for (int c = 0; c < 2; c++) begin
        if (pwm[c]) hi[c]++;
        else if (pwm_prev[c]) begin
          check_pulse(c, hi[c]);
          hi[c] = 0;
        end
        if (at_tgt[c] != at_prev[c]) check_at(c, at_tgt[c]);
      end
      pwm_prev = pwm;
      at_prev  = at_tgt;
      if (err3) check_err3();
      if (cmd_err) begin
        checks++;
        errors++;
        $display("FAIL main_cmd_err: got 1 at cycle %0d, want 0", cyc);
      end
    end
  end

  task automatic goto(input int k);
    while (cyc < k) @(negedge clk);
  endtask

  task automatic send(input logic ch, input logic [7:0] pos, input logic snap);
    cmd_valid = 1'b1; cmd_ch = ch; cmd_pos = pos; cmd_snap = snap;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_snap = 1'b0;
  endtask

  task automatic send3(input logic [1:0] ch, input logic [7:0] pos, input logic snap);
    c3_valid = 1'b1; c3_ch = ch; c3_pos = pos; c3_snap = snap;
    @(negedge clk);
    c3_valid = 1'b0; c3_snap = 1'b0;
  endtask

  task automatic push_at(input int c, input logic v, input int k);
    at_exp_q.push_back('{ch: c, val: v, cyc: k});
  endtask

  task automatic check_reset_state(input string tag);
    check_val({tag, "_pwm"}, pwm, 0);
    check_val({tag, "_at_target"}, at_tgt, 3);
    check_val({tag, "_cmd_err"}, cmd_err, 0);
    check_val({tag, "_cmd_ready"}, cmd_ready, 0);
    check_val({tag, "_pwm3"}, pwm3, 0);
    check_val({tag, "_at_target3"}, at3, 7);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish by 1 ms");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0;
    cmd_valid = 1'b0; cmd_ch = 1'b0; cmd_pos = 8'd0; cmd_snap = 1'b0; hold = 1'b0;
    c3_valid = 1'b0; c3_ch = 2'd0; c3_pos = 8'd0; c3_snap = 1'b0;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    #2 rst = 1'b0;
    #1 check_val("ready_after_reset", cmd_ready, 1);

    // Reset position 127 -> 498-cycle pulses on both channels
    w0_q.push_back(498); w0_q.push_back(498);
    w1_q.push_back(498); w1_q.push_back(498);

    // Out-of-range channel on the 3-channel instance
    goto(500);
    err3_q.push_back(501);
    send3(2'd3, 8'd0, 1'b1);
    goto(510);
    check_val("err_no_state_change", at3, 7);
    goto(600);
    send3(2'd2, 8'd0, 1'b1);

    // Ramp ch0 127 -> 130: three steps at cycles 1010/1020/1030
    goto(1005);
    push_at(0, 1'b0, 1006);
    push_at(0, 1'b1, 1030);
    w0_q.push_back(507); w0_q.push_back(507); w0_q.push_back(507);
    send(1'b0, 8'd130, 1'b0);

    // Snap ch1 to 255 at counter=300, then to 0 in the middle of its 900-cycle pulse
    goto(2300);
    w1_q.push_back(498); w1_q.push_back(900);
    send(1'b1, 8'd255, 1'b1);
    goto(3500);
    w1_q.push_back(100);
    send(1'b1, 8'd0, 1'b1);

    // Hold during a 127 -> 200 ramp: 3 steps before hold, 70 after release
    goto(4990);
    w0_q.push_back(498); w0_q.push_back(507); w0_q.push_back(507); w0_q.push_back(727);
    for (int p = 0; p < 4; p++) w1_q.push_back(100);
    send(1'b0, 8'd127, 1'b1);
    goto(5000);
    push_at(0, 1'b0, 5001);
    push_at(0, 1'b1, 7895);
    send(1'b0, 8'd200, 1'b0);
    goto(5035);
    hold = 1'b1;
    goto(7200);
    hold = 1'b0;

    // Commands colliding with step ticks (ticks land on cycles ending in 5)
    goto(8000);
    push_at(1, 1'b0, 8001);
    send(1'b1, 8'd5, 1'b0);
    goto(8024);
    send(1'b1, 8'd0, 1'b0);
    goto(8044);
    push_at(1, 1'b1, 8045);
    w1_q.push_back(162);
    send(1'b1, 8'd20, 1'b1);

    // Reset in the middle of a ramp and of ch0's pulse
    goto(9100);
    push_at(0, 1'b0, 9101);
    send(1'b0, 8'd100, 1'b0);
    goto(9300);
    #2 rst = 1'b1;
    #1 check_reset_state("midreset");
    repeat (5) @(negedge clk);
    w0_q.push_back(498); w0_q.push_back(498);
    w1_q.push_back(498); w1_q.push_back(498);
    #2 rst = 1'b0;
    goto(2010);

    check_val("pending_expectations", w0_q.size() + w1_q.size() + at_exp_q.size() + err3_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/servo_pwm_multi.md
Name: servo_pwm_multi

Overview:
- N-channel successor to the single-channel smooth servo driver. Each channel ramps its current position toward a commanded target at a programmable step rate and produces a standard servo PWM.
- Targets arrive over a valid/ready command port with per-command channel select and a snap (immediate jump) mode. Position width is parametrised.
- Pulse widths change only at period boundaries, so no runt or stretched pulses occur.
- Sits between the tracker control FSM and the pan/tilt servo pins.

Parameters:
- CLK_FREQ_HZ, 50_000_000: clock frequency.
- PERIOD_MS, 20: PWM period.
- MIN_PULSE_US, 600: pulse width at position 0.
- MAX_PULSE_US, 2400: pulse width at position POS_MAX = 2^POS_W-1.
- N_CH, 2: channel count, 1..8.
- POS_W, 8: position width, 4..12.
- STEP_DELAY_US, 8000: interval between ramp steps.
- RESET_POS, 2^(POS_W-1)-1: position and target of every channel after reset.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready.
- cmd_ch  in  CH_W=max(1,clog2(N_CH))  target channel.
- cmd_pos  in  POS_W  target position.
- cmd_snap  in  1  1 = jump current position immediately; 0 = ramp.
- hold  in  1  freezes ramping for all channels; PWM continues.
- pwm_out  out  N_CH  servo pulses.
- at_target  out  N_CH  current position == target, per channel.
- cmd_err  out  1  one-cycle pulse on an accepted command with cmd_ch >= N_CH.

Behaviour:
- Derived cycle counts: PERIOD_CYC = CLK_FREQ_HZ/1000*PERIOD_MS; MIN_CYC, MAX_CYC, STEP_CYC from the µs values via CLK_FREQ_HZ/1_000_000. All integer, truncating.
- Reset values:
  - pwm_out = 0, cmd_err = 0, at_target = all 1.
  - cmd_ready = 0 while reset is asserted.
  - Period counter = 0, step timer = 0.
  - Each cur_pos and tgt = RESET_POS.
  - Each active width = width(RESET_POS).
- cmd_ready = 1 in every cycle after reset deasserts. One command per cycle, no backpressure.
- Accepted command, cmd_ch < N_CH:
  - tgt[cmd_ch] <= cmd_pos on the next edge.
  - If cmd_snap, cur_pos[cmd_ch] <= cmd_pos on the same edge.
- Accepted command, cmd_ch >= N_CH: no state changes; cmd_err = 1 for one cycle.
- Step timer:
  - Counts 0..STEP_CYC-1 while hold = 0 and wraps.
  - step_tick is asserted in the cycle the timer equals STEP_CYC-1.
  - hold = 1 freezes the timer at its current value and suppresses step_tick.
- On step_tick, every channel independently moves cur_pos one LSB toward tgt: +1 if below, -1 if above, unchanged if equal. No overshoot and no wrap past 0 or POS_MAX.
- Simultaneous events:
  - A command and step_tick on the same channel in the same cycle: the command wins. Non-snap: new tgt is stored and the step uses the old tgt. Snap: cur_pos = cmd_pos and the step is discarded.
  - A step on other channels proceeds normally.
- Width computation: width(p) = MIN_CYC + ((MAX_CYC-MIN_CYC)*p)/POS_MAX, truncating. Intermediate width must hold (MAX_CYC-MIN_CYC)*POS_MAX without overflow; 40 bits is sufficient. May be pipelined up to 4 cycles.
- Pending width is recomputed from cur_pos. Active width loads from the pending width only in the cycle the period counter equals PERIOD_CYC-1, and takes effect from the next period.
- PWM:
  - Period counter runs 0..PERIOD_CYC-1 and wraps.
  - pwm_out[i] is registered: high when counter < active_width[i], one cycle after the counter value.
  - Each period carries exactly active_width[i] high cycles.
- at_target[i] is registered and equals (cur_pos[i] == tgt[i]).
- Asynchronous reset mid-ramp or mid-pulse: all outputs go to reset values immediately and all state returns to RESET_POS.

Test Plan:
Bench parameters for all scenarios: CLK_FREQ_HZ=1_000_000, PERIOD_MS=1 (1000 cycles), MIN_PULSE_US=100, MAX_PULSE_US=900, STEP_DELAY_US=10, POS_W=8, N_CH=2.

- Reset released -> both pwm_out high for 498 cycles each 1000-cycle period; at_target=2'b11.
- Ramp: ch0 cmd_pos=130, snap=0 -> at_target[0] drops; cur_pos reaches 130 after 3 step_ticks (~30 cycles). The next full period has a 507-cycle pulse and at_target[0] rises.
- Snap and extremes: ch1 snap 255 -> 900-cycle pulse from the next period; ch1 snap 0 -> 100-cycle pulse; at_target[1] stays 1.
- Mid-period command: snap issued at counter=300 -> the current period keeps the old width and the new width appears only in the following period.
- Hold: hold=1 during a 127->200 ramp -> cur_pos frozen and pulse constant. Release hold -> ramping resumes; 73 steps total.
- Error and collision: cmd_ch=3 -> cmd_err pulses for 1 cycle and no state changes. A command coinciding with step_tick -> the stored target is the commanded value.
- Reset mid-ramp -> pwm_out=0 immediately; after release, 498-cycle pulses resume.
